// File: rtl/write_page_ecc.sv
// NAND page-program sequencer: bad-block check, 80h/address/data, per-128-byte Hamming
// ECC appended to the spare area, 10h, R/B wait and 70h status readback.
module write_page_ecc #(
    parameter int          PAGE_BYTES   = 8192,
    parameter int          BB_LAT       = 2,
    parameter int          TWB_CYC      = 8,
    parameter logic [19:0] BUSY_TIMEOUT = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] addr_row,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [11:0] bb_ram_addr,
    input  logic        bb_ram_dout,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [7:0]  flash_dout,
    output logic        flash_cle,
    output logic        flash_ale,
    output logic        flash_we_valid,
    input  logic        flash_we_ready,
    output logic        flash_re_req,
    input  logic [7:0]  flash_din,
    input  logic        flash_din_valid,
    input  logic        flash_rb
);
    localparam int          CHUNKS     = PAGE_BYTES / 128;
    localparam logic [19:0] LAST_DATA  = 20'(PAGE_BYTES - 1);
    localparam logic [19:0] BB_WAIT    = 20'(BB_LAT + 1);
    localparam logic [19:0] TWB_LAST   = 20'(TWB_CYC - 1);
    localparam logic [19:0] TO_LAST    = BUSY_TIMEOUT - 20'd1;
    localparam logic [5:0]  LAST_CHUNK = 6'(CHUNKS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_BBCHK, S_CMD80, S_ADDR, S_DATA, S_ECC,
        S_CMD10, S_TWB, S_BUSY, S_CMD70, S_STATUS, S_DONE
    } state_t;

    function automatic logic [13:0] rp_delta(input logic [6:0] a, input logic p);
        logic [13:0] r;
        r = 14'd0;
        for (int n = 0; n < 7; n++) begin
            r[2*n+1] = p & a[n];
            r[2*n]   = p & ~a[n];
        end
        return r;
    endfunction

    function automatic logic [5:0] cp_delta(input logic [7:0] d);
        logic [5:0] c;
        logic [2:0] jb;
        c = 6'd0;
        for (int m = 0; m < 3; m++) begin
            for (int j = 0; j < 8; j++) begin
                jb = 3'(j);
                if (jb[m]) c[2*m+1] = c[2*m+1] ^ d[j];
                else       c[2*m]   = c[2*m]   ^ d[j];
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] addr_byte(input logic [2:0] idx, input logic [23:0] row);
        case (idx)
            3'd2:    return row[7:0];
            3'd3:    return row[15:8];
            3'd4:    return row[23:16];
            default: return 8'h00;
        endcase
    endfunction

    // Spare layout per chunk: rp[7:0], rp[15:8], cp[7:0].
    function automatic logic [7:0] ecc_sel(input logic [23:0] w, input logic [1:0] sub);
        case (sub)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            default: return w[23:16];
        endcase
    endfunction

    function automatic logic [1:0] status_err(input logic [7:0] s);
        return {1'b0, s[0]};
    endfunction

    state_t      state_q;
    logic [19:0] cnt_q;
    logic [23:0] row_q;
    logic [11:0] bb_addr_q;
    logic        busy_q, done_q, cle_q, ale_q, valid_q, re_req_q;
    logic [1:0]  err_q;
    logic [7:0]  byte_q;
    logic [13:0] rp_q, rp_d;
    logic [5:0]  cp_q, cp_d;
    logic [5:0]  ecc_chunk_q, nxt_chunk_s;
    logic [1:0]  ecc_sub_q, nxt_sub_s;
    logic [23:0] ecc_mem [0:CHUNKS-1];
    logic        data_mode_s, data_xfer_s, chunk_end_s, byte_xfer_s, sub_wrap_s;

    assign data_mode_s = (state_q == S_DATA) & ~rst;
    assign data_xfer_s = data_mode_s & src_valid & flash_we_ready;
    assign chunk_end_s = data_xfer_s & (cnt_q[6:0] == 7'h7f);
    assign byte_xfer_s = valid_q & flash_we_ready;
    assign rp_d        = rp_q ^ rp_delta(cnt_q[6:0], ^src_data);
    assign cp_d        = cp_q ^ cp_delta(src_data);
    assign sub_wrap_s  = (ecc_sub_q == 2'd2);
    assign nxt_sub_s   = sub_wrap_s ? 2'd0 : ecc_sub_q + 2'd1;
    assign nxt_chunk_s = sub_wrap_s ? ecc_chunk_q + 6'd1 : ecc_chunk_q;

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign bb_ram_addr    = bb_addr_q;
    assign flash_dout     = data_mode_s ? src_data : byte_q;
    assign flash_we_valid = data_mode_s ? src_valid : (valid_q & ~rst);
    assign src_ready      = data_mode_s & flash_we_ready;
    assign flash_cle      = cle_q;
    assign flash_ale      = ale_q;
    assign flash_re_req   = re_req_q;

    // Chunk syndrome is written on the 128th byte's transfer, leaving the byte stream unstalled.
    always_ff @(posedge clk) begin
        if (chunk_end_s) ecc_mem[cnt_q[12:7]] <= {2'b00, cp_d, 2'b00, rp_d};
    end

    // Sequencer with registered command/address/ECC byte and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;     cnt_q <= 20'd0;     row_q <= 24'd0;
            bb_addr_q <= 12'd0;    busy_q <= 1'b0;     done_q <= 1'b0;
            err_q <= 2'd0;         byte_q <= 8'h00;    cle_q <= 1'b0;
            ale_q <= 1'b0;         valid_q <= 1'b0;    re_req_q <= 1'b0;
            rp_q <= 14'd0;         cp_q <= 6'd0;
            ecc_chunk_q <= 6'd0;   ecc_sub_q <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    row_q <= addr_row; bb_addr_q <= addr_row[18:7];
                    busy_q <= 1'b1; err_q <= 2'd0; cnt_q <= 20'd0; state_q <= S_BBCHK;
                end
                S_BBCHK: if (cnt_q == BB_WAIT) begin
                    cnt_q <= 20'd0;
                    if (bb_ram_dout) begin
                        err_q <= 2'd2; busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                    end else begin
                        byte_q <= 8'h80; cle_q <= 1'b1; valid_q <= 1'b1; state_q <= S_CMD80;
                    end
                end else cnt_q <= cnt_q + 20'd1;
                S_CMD80: if (byte_xfer_s) begin
                    cle_q <= 1'b0; ale_q <= 1'b1; byte_q <= 8'h00; cnt_q <= 20'd0; state_q <= S_ADDR;
                end
                S_ADDR: if (byte_xfer_s) begin
                    if (cnt_q == 20'd4) begin
                        ale_q <= 1'b0; valid_q <= 1'b0; byte_q <= 8'h00; cnt_q <= 20'd0;
                        rp_q <= 14'd0; cp_q <= 6'd0; state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                        byte_q <= addr_byte(cnt_q[2:0] + 3'd1, row_q);
                    end
                end
                S_DATA: if (data_xfer_s) begin
                    rp_q <= chunk_end_s ? 14'd0 : rp_d;
                    cp_q <= chunk_end_s ? 6'd0 : cp_d;
                    if (cnt_q == LAST_DATA) begin
                        cnt_q <= 20'd0; ecc_chunk_q <= 6'd0; ecc_sub_q <= 2'd0; state_q <= S_ECC;
                    end else cnt_q <= cnt_q + 20'd1;
                end
                // One load cycle on entry, then the next spare byte is staged on every transfer.
                S_ECC: if (!valid_q) begin
                    byte_q <= ecc_sel(ecc_mem[ecc_chunk_q], ecc_sub_q); valid_q <= 1'b1;
                end else if (byte_xfer_s) begin
                    if (ecc_chunk_q == LAST_CHUNK && sub_wrap_s) begin
                        byte_q <= 8'h10; cle_q <= 1'b1; state_q <= S_CMD10;
                    end else begin
                        ecc_chunk_q <= nxt_chunk_s; ecc_sub_q <= nxt_sub_s;
                        byte_q <= ecc_sel(ecc_mem[nxt_chunk_s], nxt_sub_s);
                    end
                end
                S_CMD10: if (byte_xfer_s) begin
                    valid_q <= 1'b0; cle_q <= 1'b0; byte_q <= 8'h00; cnt_q <= 20'd0; state_q <= S_TWB;
                end
                S_TWB: if (cnt_q == TWB_LAST) begin
                    cnt_q <= 20'd0; state_q <= S_BUSY;
                end else cnt_q <= cnt_q + 20'd1;
                S_BUSY: if (flash_rb) begin
                    byte_q <= 8'h70; cle_q <= 1'b1; valid_q <= 1'b1; cnt_q <= 20'd0; state_q <= S_CMD70;
                end else if (cnt_q == TO_LAST) begin
                    err_q <= 2'd3; busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                end else cnt_q <= cnt_q + 20'd1;
                S_CMD70: if (byte_xfer_s) begin
                    valid_q <= 1'b0; cle_q <= 1'b0; byte_q <= 8'h00; re_req_q <= 1'b1; state_q <= S_STATUS;
                end
                S_STATUS: if (flash_din_valid) begin
                    re_req_q <= 1'b0; err_q <= status_err(flash_din);
                    busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
